tile_game: RTL and testbench

// - Top-level memory/tile-matching game for a DE1-class board: 10 hidden tiles (one per switch) in 5 colour pairs.
// - Player starts a game, picks two tiles, then compares them; matched pairs stay revealed on LEDs; game ends when all 5 pairs match.
// - Sole block between board I/O (SW, KEY, LEDR, HEX) and the game logic; no external memory.

---
 rtl/tile_game_pkg.sv | 56 +++++
 rtl/tile_game_hex_decoder.sv | 35 +++
 rtl/tile_game.sv | 170 +++++++++++++++++
 tb/tb_tile_game.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_game_pkg.sv
// rtl/tile_game_pkg.sv - shared encodings, colour ROM and glyphs for the tile-matching game
package tile_game_pkg;

    localparam int NUM_TILES = 10;
    localparam int NUM_PAIRS = 5;

    typedef enum logic [3:0] {
        MODE_IDLE = 4'd0,
        MODE_PLAY = 4'd1,
        MODE_OVER = 4'd2
    } game_mode_e;

    typedef enum logic [2:0] {
        SEL1    = 3'd0,
        SEL2    = 3'd1,
        WAITCMP = 3'd2,
        EVAL    = 3'd3
    } in_game_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    function automatic logic [2:0] tile_colour(input logic [3:0] idx);
        case (idx)
            4'd0:    tile_colour = 3'd1;
            4'd1:    tile_colour = 3'd2;
            4'd2:    tile_colour = 3'd3;
            4'd3:    tile_colour = 3'd4;
            4'd4:    tile_colour = 3'd2;
            4'd5:    tile_colour = 3'd4;
            4'd6:    tile_colour = 3'd3;
            4'd7:    tile_colour = 3'd1;
            4'd8:    tile_colour = 3'd5;
            4'd9:    tile_colour = 3'd5;
            default: tile_colour = 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] onehot_index(input logic [NUM_TILES-1:0] sw);
        onehot_index = 4'd0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (sw[i]) onehot_index = 4'(i);
        end
    endfunction

    function automatic logic [NUM_TILES-1:0] tile_mask(input logic [3:0] idx);
        tile_mask = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (idx == 4'(i)) tile_mask[i] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/tile_game_hex_decoder.sv
// rtl/tile_game_hex_decoder.sv - 4-bit value to active-low seven-segment pattern with blanking
module hex_decoder
    import tile_game_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (value)
                4'h0: seg = 7'b1000000;
                4'h1: seg = 7'b1111001;
                4'h2: seg = 7'b0100100;
                4'h3: seg = 7'b0110000;
                4'h4: seg = 7'b0011001;
                4'h5: seg = 7'b0010010;
                4'h6: seg = 7'b0000010;
                4'h7: seg = 7'b1111000;
                4'h8: seg = 7'b0000000;
                4'h9: seg = 7'b0010000;
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                4'hF: seg = 7'b0001110;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/tile_game.sv
// rtl/tile_game.sv - memory tile-matching game top: key conditioning, game FSMs, counters, display
module tile_game
    import tile_game_pkg::*;
(
    input  logic                 CLOCK_50,
    input  logic [3:0]           KEY,
    input  logic [NUM_TILES-1:0] SW,
    output logic [NUM_TILES-1:0] LEDR,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3,
    output logic [6:0]           HEX4,
    output logic [6:0]           HEX5
);

    logic rst;
    assign rst = ~KEY[0];

    // Keys idle high, so the chain resets to 1 to avoid a phantom press on release of reset
    logic [3:1] key_meta_q, key_sync_q, key_prev_q;
    logic [3:1] press;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            key_prev_q <= '1;
        end else begin
            key_meta_q <= KEY[3:1];
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    assign press = key_prev_q & ~key_sync_q;

    game_mode_e           gameModeState, gameModeState_d;
    in_game_e             inGameState, inGameState_d;
    logic [NUM_TILES-1:0] matched_q, matched_d;
    logic [2:0]           pairs_q, pairs_d;
    logic [3:0]           att_units_q, att_units_d;
    logic [3:0]           att_tens_q, att_tens_d;
    logic [3:0]           first_q, first_d;
    logic                 first_valid_q, first_valid_d;
    logic [3:0]           second_q, second_d;
    logic                 second_valid_q, second_valid_d;

    logic       sw_onehot;
    logic [3:0] sw_idx;
    logic       sw_free;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            gameModeState  <= MODE_IDLE;
            inGameState    <= SEL1;
            matched_q      <= '0;
            pairs_q        <= '0;
            att_units_q    <= '0;
            att_tens_q     <= '0;
            first_q        <= '0;
            first_valid_q  <= 1'b0;
            second_q       <= '0;
            second_valid_q <= 1'b0;
        end else begin
            gameModeState  <= gameModeState_d;
            inGameState    <= inGameState_d;
            matched_q      <= matched_d;
            pairs_q        <= pairs_d;
            att_units_q    <= att_units_d;
            att_tens_q     <= att_tens_d;
            first_q        <= first_d;
            first_valid_q  <= first_valid_d;
            second_q       <= second_d;
            second_valid_q <= second_valid_d;
        end
    end

    always_comb begin
        gameModeState_d = gameModeState;
        inGameState_d   = inGameState;
        matched_d       = matched_q;
        pairs_d         = pairs_q;
        att_units_d     = att_units_q;
        att_tens_d      = att_tens_q;
        first_d         = first_q;
        first_valid_d   = first_valid_q;
        second_d        = second_q;
        second_valid_d  = second_valid_q;

        sw_onehot = $onehot(SW);
        sw_idx    = onehot_index(SW);
        sw_free   = sw_onehot && !matched_q[sw_idx];

        case (gameModeState)
            MODE_IDLE, MODE_OVER: begin
                if (press[1]) begin
                    gameModeState_d = MODE_PLAY;
                    inGameState_d   = SEL1;
                    matched_d       = '0;
                    pairs_d         = '0;
                    att_units_d     = '0;
                    att_tens_d      = '0;
                    first_valid_d   = 1'b0;
                    second_valid_d  = 1'b0;
                end
            end
            MODE_PLAY: begin
                case (inGameState)
                    SEL1: begin
                        if (press[2] && sw_free) begin
                            first_d       = sw_idx;
                            first_valid_d = 1'b1;
                            inGameState_d = SEL2;
                        end
                    end
                    SEL2: begin
                        if (press[3] && sw_free && sw_idx != first_q) begin
                            second_d       = sw_idx;
                            second_valid_d = 1'b1;
                            inGameState_d  = WAITCMP;
                        end
                    end
                    WAITCMP: begin
                        if (press[2]) inGameState_d = EVAL;
                    end
                    EVAL: begin
                        if (!(att_tens_q == 4'd9 && att_units_q == 4'd9)) begin
                            if (att_units_q == 4'd9) begin
                                att_units_d = 4'd0;
                                att_tens_d  = att_tens_q + 4'd1;
                            end else begin
                                att_units_d = att_units_q + 4'd1;
                            end
                        end
                        if (tile_colour(first_q) == tile_colour(second_q)) begin
                            matched_d = matched_q | tile_mask(first_q) | tile_mask(second_q);
                            pairs_d   = pairs_q + 3'd1;
                            if (pairs_q == 3'(NUM_PAIRS - 1)) gameModeState_d = MODE_OVER;
                        end
                        first_valid_d  = 1'b0;
                        second_valid_d = 1'b0;
                        inGameState_d  = SEL1;
                    end
                    default: inGameState_d = SEL1;
                endcase
            end
            default: gameModeState_d = MODE_IDLE;
        endcase
    end

    assign LEDR = (gameModeState == MODE_IDLE) ? '0 : matched_q;

    hex_decoder u_hex0 (.value({1'b0, tile_colour(first_q)}),  .blank(~first_valid_q),  .seg(HEX0));
    hex_decoder u_hex1 (.value({1'b0, tile_colour(second_q)}), .blank(~second_valid_q), .seg(HEX1));
    hex_decoder u_hex2 (.value({1'b0, pairs_q}),                .blank(1'b0),            .seg(HEX2));
    hex_decoder u_hex3 (.value(att_units_q),                    .blank(1'b0),            .seg(HEX3));
    hex_decoder u_hex4 (.value(att_tens_q),                     .blank(1'b0),            .seg(HEX4));

    always_comb begin
        HEX5 = SEG_BLANK;
        case (gameModeState)
            MODE_IDLE: HEX5 = SEG_I;
            MODE_PLAY: HEX5 = SEG_P;
            MODE_OVER: HEX5 = SEG_E;
            default:   HEX5 = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_tile_game.sv
// tb/tb_tile_game.sv - scoreboard bench for the tile-matching game
module tb_tile_game;

    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    always #10 CLOCK_50 = ~CLOCK_50;

    tile_game dut (
        .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    typedef struct {
        string       name;
        logic [58:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    int         col[10] = '{1, 2, 3, 4, 2, 4, 3, 1, 5, 5};
    int         m_mode, m_ig, m_pairs, m_att, m_first, m_second;
    logic [9:0] m_matched;

    function automatic logic [6:0] seg7(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [58:0] model_vec();
        logic [6:0] h0, h1, h5;
        h0 = (m_first < 0) ? 7'h7F : seg7(col[m_first]);
        h1 = (m_second < 0) ? 7'h7F : seg7(col[m_second]);
        h5 = (m_mode == 0) ? 7'b1111001 : (m_mode == 1) ? 7'b0001100 : 7'b0000110;
        return {4'(m_mode), 3'(m_ig), (m_mode == 0) ? 10'd0 : m_matched,
                h5, seg7(m_att / 10), seg7(m_att % 10), seg7(m_pairs), h1, h0};
    endfunction

    function automatic logic [58:0] dut_vec();
        return {dut.gameModeState, dut.inGameState, LEDR, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_ig = 0; m_pairs = 0; m_att = 0;
        m_first = -1; m_second = -1; m_matched = '0;
    endfunction

    function automatic int sw_index(input logic [9:0] sw);
        if ($countones(sw) != 1) return -1;
        for (int i = 0; i < 10; i++) if (sw[i]) return i;
        return -1;
    endfunction

    function automatic void model_press(input int k, input logic [9:0] sw);
        int idx;
        idx = sw_index(sw);
        if (k == 1 && m_mode != 1) begin
            m_mode = 1; m_ig = 0; m_pairs = 0; m_att = 0;
            m_first = -1; m_second = -1; m_matched = '0;
        end else if (m_mode == 1) begin
            if (k == 2 && m_ig == 0 && idx >= 0 && !m_matched[idx]) begin
                m_first = idx; m_ig = 1;
            end else if (k == 3 && m_ig == 1 && idx >= 0 && !m_matched[idx] && idx != m_first) begin
                m_second = idx; m_ig = 2;
            end else if (k == 2 && m_ig == 2) begin
                if (m_att < 99) m_att++;
                if (col[m_first] == col[m_second]) begin
                    m_matched[m_first]  = 1'b1;
                    m_matched[m_second] = 1'b1;
                    m_pairs++;
                    if (m_pairs == 5) m_mode = 2;
                end
                m_first = -1; m_second = -1; m_ig = 0;
            end
        end
    endfunction

    task automatic press(input int k, input logic [9:0] sw, input string name);
        @(negedge CLOCK_50);
        SW = sw;
        KEY[k] = 1'b0;
        model_press(k, sw);
        sb.push_back('{name, model_vec()});
        repeat (4) @(negedge CLOCK_50);
        KEY[k] = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic reset_on(input string name);
        @(negedge CLOCK_50);
        #2;
        KEY = 4'b1110;
        model_reset();
        sb.push_back('{name, model_vec()});
        #1;
    endtask

    task automatic reset_off();
        repeat (3) @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        reset_on("reset_async");
        e = sb.pop_front(); n_cmp++;
        if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        reset_off();
        sb.push_back('{"reset_released", model_vec()});
        e = sb.pop_front(); n_cmp++;
        if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
    endtask

    task automatic test_start();
        press(1, 10'd0, "start");
        e = sb.pop_front(); n_cmp++;
        if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
    endtask

    task automatic test_no_match();
        int         k_tab[3]  = '{2, 3, 2};
        logic [9:0] sw_tab[3] = '{10'b0000000001, 10'b0000000010, 10'b0};
        for (int i = 0; i < 3; i++) begin
            press(k_tab[i], sw_tab[i], $sformatf("no_match_step%0d", i));
            e = sb.pop_front(); n_cmp++;
            if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        end
    endtask

    task automatic test_pairs();
        int pa[4] = '{0, 1, 2, 3};
        int pb[4] = '{7, 4, 6, 5};
        for (int p = 0; p < 4; p++) begin
            press(2, 10'(1) << pa[p], $sformatf("pair%0d_first", p));
            e = sb.pop_front(); n_cmp++;
            if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
            press(3, 10'(1) << pb[p], $sformatf("pair%0d_second", p));
            e = sb.pop_front(); n_cmp++;
            if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
            press(2, 10'd0, $sformatf("pair%0d_compare", p));
            e = sb.pop_front(); n_cmp++;
            if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        end
    endtask

    task automatic test_illegal();
        int         k_tab[10]  = '{2, 2, 2, 3, 1, 2, 3, 3, 3, 2};
        logic [9:0] sw_tab[10] = '{10'b0, 10'b0000000011, 10'b0000000001, 10'b0100000000,
                                   10'b0, 10'b0100000000, 10'b0100000000, 10'b0000000001,
                                   10'b0, 10'b1000000000};
        for (int i = 0; i < 10; i++) begin
            press(k_tab[i], sw_tab[i], $sformatf("illegal_step%0d", i));
            e = sb.pop_front(); n_cmp++;
            if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        end
    endtask

    task automatic test_finish();
        int         k_tab[4]  = '{3, 2, 2, 3};
        logic [9:0] sw_tab[4] = '{10'b1000000000, 10'b0, 10'b0000000001, 10'b0000000010};
        for (int i = 0; i < 4; i++) begin
            press(k_tab[i], sw_tab[i], $sformatf("finish_step%0d", i));
            e = sb.pop_front(); n_cmp++;
            if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        end
        n_cmp++;
        if (LEDR !== 10'h3FF) begin n_fail++; $display("FAIL finish_ledr got=%h exp=%h", LEDR, 10'h3FF); end
        reset_on("reset_after_over");
        e = sb.pop_front(); n_cmp++;
        if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        reset_off();
    endtask

    task automatic test_saturation();
        press(1, 10'd0, "sat_start");
        e = sb.pop_front(); n_cmp++;
        if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        for (int r = 0; r < 101; r++) begin
            press(2, 10'b0000000001, "sat_first");
            void'(sb.pop_front());
            press(3, 10'b0000000010, "sat_second");
            void'(sb.pop_front());
            press(2, 10'd0, $sformatf("sat_round%0d", r));
            e = sb.pop_front(); n_cmp++;
            if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        end
    endtask

    task automatic test_reset_mid_game();
        press(1, 10'd0, "mid_start");
        void'(sb.pop_front());
        press(2, 10'b0000000100, "mid_first");
        void'(sb.pop_front());
        press(3, 10'b0001000000, "mid_second");
        e = sb.pop_front(); n_cmp++;
        if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        reset_on("reset_mid_game");
        e = sb.pop_front(); n_cmp++;
        if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        reset_off();
        press(1, 10'd0, "restart");
        e = sb.pop_front(); n_cmp++;
        if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        press(2, 10'b0000000001, "restart_first");
        e = sb.pop_front(); n_cmp++;
        if (dut_vec() !== e.v) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.name, dut_vec(), e.v); end
        n_cmp++;
        if (HEX0 !== 7'h79) begin n_fail++; $display("FAIL restart_hex0 got=%h exp=%h", HEX0, 7'h79); end
    endtask

    initial begin
        KEY = 4'b1111;
        SW  = '0;
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        test_reset();
        test_start();
        test_no_match();
        test_pairs();
        test_illegal();
        test_finish();
        test_saturation();
        test_reset_mid_game();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
